// File: rtl/btn_debounce_if.sv
// btn_debounce_if: raw button level in, debounced level, event strobes and press count out
interface btn_debounce_if;
    logic       btn_raw;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press;
    logic [7:0] press_count;
    modport master (output btn_raw, input btn_level, press_pulse, release_pulse, long_press, press_count);
    modport slave (input btn_raw, output btn_level, press_pulse, release_pulse, long_press, press_count);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: synchronized push-button qualifier with press/release/long-press strobes and press counter
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int LONG_CYCLES     = 25_000_000
) (
    input logic           clk,
    input logic           rst,
    btn_debounce_if.slave bus
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t        state, state_n;
    logic [1:0]    sync;
    logic          btn_sync;
    logic [CW-1:0] cnt, cnt_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic          long_fired, fired_n;
    logic          level_q, level_n;
    logic          press_q, press_n;
    logic          rel_q, rel_n;
    logic          long_q, long_n;
    logic [7:0]    count_q, count_n;

    assign btn_sync          = sync[1];
    assign bus.btn_level     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = rel_q;
    assign bus.long_press    = long_q;
    assign bus.press_count   = count_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) sync <= 2'b00;
        else     sync <= {sync[0], bus.btn_raw};

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hold_cnt   <= '0;
            long_fired <= 1'b0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
            long_q     <= 1'b0;
            count_q    <= 8'd0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            hold_cnt   <= hold_n;
            long_fired <= fired_n;
            level_q    <= level_n;
            press_q    <= press_n;
            rel_q      <= rel_n;
            long_q     <= long_n;
            count_q    <= count_n;
        end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hold_n  = hold_cnt;
        fired_n = long_fired;
        level_n = level_q;
        press_n = 1'b0;
        rel_n   = 1'b0;
        long_n  = 1'b0;
        count_n = count_q;
        // hold time keeps running through release bounces; long_press fires once after saturation
        if (state == HELD || state == RELEASE_WAIT) begin
            if (hold_cnt != HOLD_LAST) hold_n = hold_cnt + 1'b1;
            else if (!long_fired) begin
                long_n  = 1'b1;
                fired_n = 1'b1;
            end
        end
        case (state)
            IDLE: if (btn_sync) begin
                state_n = PRESS_WAIT;
                cnt_n   = '0;
            end
            PRESS_WAIT:
                if (!btn_sync) state_n = IDLE;
                else if (cnt == CNT_LAST) begin
                    state_n = HELD;
                    level_n = 1'b1;
                    press_n = 1'b1;
                    hold_n  = '0;
                    fired_n = 1'b0;
                    count_n = count_q + 8'd1;
                end else cnt_n = cnt + 1'b1;
            HELD: if (!btn_sync) begin
                state_n = RELEASE_WAIT;
                cnt_n   = '0;
            end
            RELEASE_WAIT:
                if (btn_sync) state_n = HELD;
                else if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                    level_n = 1'b0;
                    rel_n   = 1'b1;
                    long_n  = 1'b0;
                end else cnt_n = cnt + 1'b1;
        endcase
    end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed latency/table checks plus random stimulus against a run-length reference model
module tb_btn_debounce;
    localparam int D = 4;
    localparam int L = 20;

    logic clk, rst;
    btn_debounce_if ifc ();

    btn_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (.clk(clk), .rst(rst), .bus(ifc));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vecs = 0, errs = 0;
    int npress = 0, nrel = 0, nlong = 0;

    // reference: the level flips once the synchronized input has disagreed with it for D+1 samples
    logic       m1, m2, ms;
    int         run, age;
    logic       e_level, e_press, e_rel, e_long;
    logic [7:0] e_count;

    always @(posedge clk or posedge rst)
        if (rst) begin
            m1 = 0; m2 = 0; run = 0; age = 0;
            e_level = 0; e_press = 0; e_rel = 0; e_long = 0; e_count = 0;
        end else begin
            ms = m2; m2 = m1; m1 = ifc.btn_raw;
            e_press = 0; e_rel = 0; e_long = 0;
            if (e_level) age++;
            run = (ms != e_level) ? run + 1 : 0;
            if (run == D + 1) begin
                run = 0;
                e_level = ms;
                if (ms) begin
                    e_press = 1; e_count = e_count + 8'd1; age = 0;
                end else e_rel = 1;
            end
            if (e_level && age == L) e_long = 1;
        end

    task automatic tick();
        @(negedge clk);
        vecs++;
        if ({ifc.btn_level, ifc.press_pulse, ifc.release_pulse, ifc.long_press, ifc.press_count} !==
            {e_level, e_press, e_rel, e_long, e_count}) begin
            errs++;
            $display("FAIL model t=%0t: got lvl/pr/rl/lg/cnt=%b%b%b%b/%0d expected %b%b%b%b/%0d", $time,
                     ifc.btn_level, ifc.press_pulse, ifc.release_pulse, ifc.long_press, ifc.press_count,
                     e_level, e_press, e_rel, e_long, e_count);
        end
        npress += int'(ifc.press_pulse);
        nrel   += int'(ifc.release_pulse);
        nlong  += int'(ifc.long_press);
    endtask

    task automatic check(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_press(output int n);
        n = 0;
        do begin tick(); n++; end while (!ifc.press_pulse && n < 60);
    endtask

    task automatic wait_release(output int n);
        n = 0;
        do begin tick(); n++; end while (!ifc.release_pulse && n < 60);
    endtask

    typedef struct {
        logic raw;
        int   cyc;
        logic lvl;
        int   cnt;
    } vec_t;
    vec_t tbl[12];

    initial begin
        int n, p0, r0, l0;
        tbl[0]  = '{1'b1, 3,  1'b0, 1};
        tbl[1]  = '{1'b0, 10, 1'b0, 1};
        tbl[2]  = '{1'b1, 10, 1'b1, 2};
        tbl[3]  = '{1'b0, 2,  1'b1, 2};
        tbl[4]  = '{1'b1, 5,  1'b1, 2};
        tbl[5]  = '{1'b0, 10, 1'b0, 2};
        tbl[6]  = '{1'b1, 2,  1'b0, 2};
        tbl[7]  = '{1'b0, 1,  1'b0, 2};
        tbl[8]  = '{1'b1, 2,  1'b0, 2};
        tbl[9]  = '{1'b0, 8,  1'b0, 2};
        tbl[10] = '{1'b1, 12, 1'b1, 3};
        tbl[11] = '{1'b0, 12, 1'b0, 3};

        rst = 1'b1;
        ifc.btn_raw = 1'b0;
        repeat (3) tick();
        check("reset_level", int'(ifc.btn_level), 0);
        check("reset_count", int'(ifc.press_count), 0);
        check("reset_pulses", int'({ifc.press_pulse, ifc.release_pulse, ifc.long_press}), 0);
        rst = 1'b0;
        repeat (4) tick();

        // clean press latency, single long press, release latency
        ifc.btn_raw = 1'b1;
        wait_press(n);
        check("press_latency", n, 7);
        check("press_count_1", int'(ifc.press_count), 1);
        n = 0;
        do begin tick(); n++; end while (!ifc.long_press && n < 60);
        check("long_latency", n, 20);
        l0 = nlong;
        repeat (15) tick();
        check("long_once", nlong - l0, 0);
        check("held_level", int'(ifc.btn_level), 1);
        ifc.btn_raw = 1'b0;
        wait_release(n);
        check("release_latency", n, 7);
        tick();
        check("released_level", int'(ifc.btn_level), 0);

        foreach (tbl[i]) begin
            ifc.btn_raw = tbl[i].raw;
            repeat (tbl[i].cyc) tick();
            check($sformatf("tbl%0d_level", i), int'(ifc.btn_level), int'(tbl[i].lvl));
            check($sformatf("tbl%0d_count", i), int'(ifc.press_count), tbl[i].cnt);
        end

        // reset partway through qualification with the button still held
        ifc.btn_raw = 1'b1;
        repeat (5) tick();
        #2 rst = 1'b1;
        repeat (2) tick();
        check("rst_mid_outputs", int'({ifc.btn_level, ifc.press_pulse, ifc.release_pulse, ifc.long_press}), 0);
        check("rst_mid_count", int'(ifc.press_count), 0);
        #1 rst = 1'b0;
        wait_press(n);
        check("post_reset_latency", n, 7);
        check("post_reset_count", int'(ifc.press_count), 1);
        ifc.btn_raw = 1'b0;
        repeat (12) tick();

        // 256 presses wrap the counter
        @(negedge clk) rst = 1'b1;
        tick();
        rst = 1'b0;
        p0 = npress;
        r0 = nrel;
        for (int i = 0; i < 256; i++) begin
            ifc.btn_raw = 1'b1;
            repeat (8) tick();
            ifc.btn_raw = 1'b0;
            repeat (8) tick();
            if (i == 254) check("count_255", int'(ifc.press_count), 255);
        end
        check("wrap_count", int'(ifc.press_count), 0);
        check("wrap_presses", npress - p0, 256);
        check("wrap_releases", nrel - r0, 256);

        for (int i = 0; i < 400; i++) begin
            ifc.btn_raw = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 30)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
